// File: rtl/ras_update_sched_pkg.sv
// Shared BPU/RAS types: commit request payload, RAS type encodings and the
// branch-type decode helpers used by both the RAS and its update scheduler.
`ifndef RAS_INFLIGHT_SIZE
`define RAS_INFLIGHT_SIZE 16
`endif

package bpu_pkg;

  localparam int VADDR_W   = 32;
  localparam int FSQ_IDX_W = 6;
  localparam int OFFSET_W  = 4;

  localparam logic [1:0] RAS_NONE     = 2'b00;
  localparam logic [1:0] RAS_POP      = 2'b01;
  localparam logic [1:0] RAS_PUSH     = 2'b10;
  localparam logic [1:0] RAS_POP_PUSH = 2'b11;

  typedef enum logic [2:0] {
    BR_NONE    = 3'd0,
    BR_COND    = 3'd1,
    BR_JAL     = 3'd2,
    BR_JALR    = 3'd3,
    BR_CALL    = 3'd4,
    BR_RET     = 3'd5,
    BR_RETCALL = 3'd6
  } br_type_e;

  typedef struct packed {
    br_type_e              br_type;
    logic [OFFSET_W-1:0]   offset;
    logic                  rvc;
  } TailSlot;

  typedef struct packed {
    logic [VADDR_W-1:0]    start_addr;
    TailSlot               tailSlot;
    logic                  tailTaken;
    logic [FSQ_IDX_W-1:0]  fsqIdx;
  } RasCommitReq;

  function automatic logic [1:0] getRasType(input br_type_e t);
    case (t)
      BR_CALL:    return RAS_PUSH;
      BR_RET:     return RAS_POP;
      BR_RETCALL: return RAS_POP_PUSH;
      default:    return RAS_NONE;
    endcase
  endfunction

  function automatic logic rasValid(input br_type_e t);
    return getRasType(t) != RAS_NONE;
  endfunction

endpackage

// File: rtl/ras_update_sched_fifo.sv
// Commit-update FIFO: flop array with dir-bit pointers; head is read
// combinationally from the array so it is stable whenever no pop occurs.
module ras_commit_fifo
  import bpu_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  RasCommitReq data_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output RasCommitReq head_o
);

  localparam int IDX_W = $clog2(QDEPTH);
  localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

  RasCommitReq      mem_q [QDEPTH];
  logic [IDX_W:0]   wrPtr_q, wrPtr_d;
  logic [IDX_W:0]   rdPtr_q, rdPtr_d;
  logic             doPush, doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[IDX_W-1:0] == rdPtr_q[IDX_W-1:0]) &&
                   (wrPtr_q[IDX_W] != rdPtr_q[IDX_W]);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign head_o  = mem_q[rdPtr_q[IDX_W-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
    if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Payload storage needs no reset: empty pointers make stale entries invisible.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[IDX_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/ras_update_sched.sv
// RAS update scheduler: filters/queues committed RAS updates, drains one per
// unsquashed cycle, and tracks in-flight speculative pushes to stall the BPU.
`ifndef RAS_INFLIGHT_SIZE
`define RAS_INFLIGHT_SIZE 16
`endif

module ras_update_sched
  import bpu_pkg::*;
#(
  parameter int QDEPTH       = 4,
  parameter int INFL_SIZE    = `RAS_INFLIGHT_SIZE,
  parameter int STALL_MARGIN = 2,
  parameter int CNT_W        = $clog2(INFL_SIZE) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  RasCommitReq      upd_info,
  input  logic             lookup_req,
  input  logic [1:0]       lookup_type,
  input  logic             squash,
  input  logic [1:0]       squash_type,
  input  logic [CNT_W-1:0] squash_cnt,
  output logic             ras_update,
  output RasCommitReq      ras_upd_info,
  output logic             bpu_stall,
  output logic [CNT_W-1:0] infl_cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(INFL_SIZE);
  localparam logic [CNT_W-1:0] STALL_TH = CNT_W'(INFL_SIZE - STALL_MARGIN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             fifoFull, fifoEmpty, fifoPush;
  RasCommitReq      headReq;
  logic [1:0]       headType;
  logic             lookupPush, drainPush;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             unusedBits;

  assign upd_ready  = ~fifoFull;
  assign fifoPush   = upd_valid & upd_ready & upd_info.tailTaken &
                      rasValid(upd_info.tailSlot.br_type);
  assign ras_update = ~fifoEmpty & ~squash;
  assign ras_upd_info = headReq;

  ras_commit_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifoPush),
    .data_i  (upd_info),
    .pop_i   (ras_update),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .head_o  (headReq)
  );

  assign headType   = getRasType(headReq.tailSlot.br_type);
  assign drainPush  = ras_update & headType[1] & ~headType[0];
  assign lookupPush = lookup_req & lookup_type[1];
  assign unusedBits = lookup_type[0];

  // Squash restores the snapshot and overrides any lookup/drain that cycle;
  // out-of-range steps flag err and saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (squash) begin
      if (squash_type == RAS_PUSH) begin
        if (squash_cnt >= CNT_MAX) begin
          cnt_d = CNT_MAX;
          err_d = 1'b1;
        end else begin
          cnt_d = squash_cnt + CNT_ONE;
        end
      end else begin
        cnt_d = squash_cnt;
      end
    end else if (lookupPush && !drainPush) begin
      if (cnt_q == CNT_MAX) err_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_ONE;
    end else if (drainPush && !lookupPush) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign infl_cnt  = cnt_q;
  assign err       = err_q;
  assign bpu_stall = (cnt_q >= STALL_TH);

endmodule

// File: tb/tb_ras_update_sched.sv
// Directed self-checking bench for ras_update_sched with hand-computed
// expected values for reset, filtering, FIFO full, stall, squash and error cases.
module tb_ras_update_sched;
  import bpu_pkg::*;

  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             upd_valid;
  logic             upd_ready;
  RasCommitReq      upd_info;
  logic             lookup_req;
  logic [1:0]       lookup_type;
  logic             squash;
  logic [1:0]       squash_type;
  logic [CNT_W-1:0] squash_cnt;
  logic             ras_update;
  RasCommitReq      ras_upd_info;
  logic             bpu_stall;
  logic [CNT_W-1:0] infl_cnt;
  logic             err;

  int nVec = 0;
  int nErr = 0;

  ras_update_sched dut (
    .clk          (clk),
    .rst          (rst),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_info     (upd_info),
    .lookup_req   (lookup_req),
    .lookup_type  (lookup_type),
    .squash       (squash),
    .squash_type  (squash_type),
    .squash_cnt   (squash_cnt),
    .ras_update   (ras_update),
    .ras_upd_info (ras_upd_info),
    .bpu_stall    (bpu_stall),
    .infl_cnt     (infl_cnt),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd_valid   = 1'b0;
    upd_info    = '0;
    lookup_req  = 1'b0;
    lookup_type = 2'b00;
    squash      = 1'b0;
    squash_type = 2'b00;
    squash_cnt  = '0;
  endtask

  function automatic RasCommitReq mkReq(input br_type_e t, input logic taken,
                                        input logic [FSQ_IDX_W-1:0] idx);
    RasCommitReq r;
    r = '0;
    r.start_addr       = 32'h8000_0000 | {22'd0, idx, 4'h0};
    r.tailSlot.br_type = t;
    r.tailSlot.offset  = 4'd3;
    r.tailSlot.rvc     = idx[0];
    r.tailTaken        = taken;
    r.fsqIdx           = idx;
    return r;
  endfunction

  task automatic test_reset();
    nVec++; if (upd_ready !== 1'b1) begin nErr++; $display("[TB] FAIL rst_ready: got %b want 1", upd_ready); end
    nVec++; if (ras_update !== 1'b0) begin nErr++; $display("[TB] FAIL rst_update: got %b want 0", ras_update); end
    nVec++; if (bpu_stall !== 1'b0) begin nErr++; $display("[TB] FAIL rst_stall: got %b want 0", bpu_stall); end
    nVec++; if (infl_cnt !== 5'd0) begin nErr++; $display("[TB] FAIL rst_cnt: got %0d want 0", infl_cnt); end
    nVec++; if (err !== 1'b0) begin nErr++; $display("[TB] FAIL rst_err: got %b want 0", err); end
    squash = 1'b1;
    squash_cnt = 5'd7;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1;
      upd_info  = mkReq(BR_CALL, 1'b1, FSQ_IDX_W'(i + 1));
      tick();
    end
    upd_valid = 1'b0;
    #1;
    nVec++; if (infl_cnt !== 5'd7) begin nErr++; $display("[TB] FAIL burst_cnt: got %0d want 7", infl_cnt); end
    rst = 1'b1;
    #1;
    idle();
    tick();
    rst = 1'b0;
    #1;
    nVec++; if (ras_update !== 1'b0) begin nErr++; $display("[TB] FAIL midrst_update: got %b want 0", ras_update); end
    nVec++; if (infl_cnt !== 5'd0) begin nErr++; $display("[TB] FAIL midrst_cnt: got %0d want 0", infl_cnt); end
    nVec++; if (upd_ready !== 1'b1) begin nErr++; $display("[TB] FAIL midrst_ready: got %b want 1", upd_ready); end
    tick();
    nVec++; if (ras_update !== 1'b0) begin nErr++; $display("[TB] FAIL midrst_update2: got %b want 0", ras_update); end
  endtask

  task automatic test_filter();
    br_type_e types [4];
    logic     taken [4];
    types = '{BR_CALL, BR_COND, BR_JAL, BR_NONE};
    taken = '{1'b0, 1'b1, 1'b1, 1'b1};
    idle();
    for (int i = 0; i < 4; i++) begin
      upd_valid = 1'b1;
      upd_info  = mkReq(types[i], taken[i], FSQ_IDX_W'(i + 40));
      #1;
      nVec++; if (upd_ready !== 1'b1) begin nErr++; $display("[TB] FAIL filt_ready[%0d]: got %b want 1", i, upd_ready); end
      nVec++; if (ras_update !== 1'b0) begin nErr++; $display("[TB] FAIL filt_update[%0d]: got %b want 0", i, ras_update); end
      tick();
    end
    upd_valid = 1'b0;
    #1;
    nVec++; if (ras_update !== 1'b0) begin nErr++; $display("[TB] FAIL filt_after: got %b want 0", ras_update); end
    upd_valid = 1'b1;
    upd_info  = mkReq(BR_RET, 1'b1, 6'd9);
    #1;
    nVec++; if (ras_update !== 1'b0) begin nErr++; $display("[TB] FAIL lat_N: got %b want 0", ras_update); end
    tick();
    upd_valid = 1'b0;
    #1;
    nVec++; if (ras_update !== 1'b1) begin nErr++; $display("[TB] FAIL lat_N1: got %b want 1", ras_update); end
    nVec++; if (ras_upd_info !== mkReq(BR_RET, 1'b1, 6'd9)) begin nErr++; $display("[TB] FAIL lat_info: got %h want %h", ras_upd_info, mkReq(BR_RET, 1'b1, 6'd9)); end
    tick();
    nVec++; if (ras_update !== 1'b0) begin nErr++; $display("[TB] FAIL lat_drained: got %b want 0", ras_update); end
    nVec++; if (infl_cnt !== 5'd0 || err !== 1'b0) begin nErr++; $display("[TB] FAIL lat_cnt_err: got cnt=%0d err=%b want 0/0", infl_cnt, err); end
  endtask

  task automatic test_full();
    idle();
    squash = 1'b1;
    squash_cnt = 5'd8;
    for (int k = 0; k < 5; k++) begin
      upd_valid = 1'b1;
      upd_info  = mkReq(BR_CALL, 1'b1, FSQ_IDX_W'(k + 1));
      #1;
      nVec++; if (upd_ready !== ((k < 4) ? 1'b1 : 1'b0)) begin nErr++; $display("[TB] FAIL full_ready[%0d]: got %b want %b", k, upd_ready, (k < 4)); end
      nVec++; if (ras_update !== 1'b0) begin nErr++; $display("[TB] FAIL full_blocked[%0d]: got %b want 0", k, ras_update); end
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      #1;
      nVec++; if (ras_update !== 1'b1) begin nErr++; $display("[TB] FAIL drain_upd[%0d]: got %b want 1", k, ras_update); end
      nVec++; if (ras_upd_info.fsqIdx !== FSQ_IDX_W'(k + 1)) begin nErr++; $display("[TB] FAIL drain_order[%0d]: got %0d want %0d", k, ras_upd_info.fsqIdx, k + 1); end
      if (k == 0) begin
        nVec++; if (upd_ready !== 1'b0) begin nErr++; $display("[TB] FAIL full_deq_ready: got %b want 0", upd_ready); end
      end
      tick();
    end
    #1;
    nVec++; if (ras_update !== 1'b0) begin nErr++; $display("[TB] FAIL drain_done: got %b want 0", ras_update); end
    nVec++; if (infl_cnt !== 5'd4) begin nErr++; $display("[TB] FAIL drain_cnt: got %0d want 4", infl_cnt); end
    nVec++; if (upd_ready !== 1'b1) begin nErr++; $display("[TB] FAIL drain_ready: got %b want 1", upd_ready); end
  endtask

  task automatic test_stall();
    idle();
    squash = 1'b1;
    squash_cnt = 5'd0;
    tick();
    idle();
    for (int i = 0; i < 14; i++) begin
      lookup_req  = 1'b1;
      lookup_type = RAS_PUSH;
      if (i == 13) begin
        #1;
        nVec++; if (bpu_stall !== 1'b0 || infl_cnt !== 5'd13) begin nErr++; $display("[TB] FAIL stall_13: got stall=%b cnt=%0d want 0/13", bpu_stall, infl_cnt); end
      end
      tick();
    end
    idle();
    #1;
    nVec++; if (infl_cnt !== 5'd14) begin nErr++; $display("[TB] FAIL stall_cnt14: got %0d want 14", infl_cnt); end
    nVec++; if (bpu_stall !== 1'b1) begin nErr++; $display("[TB] FAIL stall_14: got %b want 1", bpu_stall); end
    upd_valid = 1'b1;
    upd_info  = mkReq(BR_CALL, 1'b1, 6'd20);
    tick();
    idle();
    #1;
    nVec++; if (ras_update !== 1'b1) begin nErr++; $display("[TB] FAIL stall_drain: got %b want 1", ras_update); end
    tick();
    nVec++; if (infl_cnt !== 5'd13 || bpu_stall !== 1'b0) begin nErr++; $display("[TB] FAIL stall_release: got cnt=%0d stall=%b want 13/0", infl_cnt, bpu_stall); end
  endtask

  task automatic test_squash();
    idle();
    squash = 1'b1;
    squash_cnt = 5'd9;
    upd_valid = 1'b1;
    upd_info  = mkReq(BR_CALL, 1'b1, 6'd12);
    tick();
    idle();
    #1;
    nVec++; if (infl_cnt !== 5'd9) begin nErr++; $display("[TB] FAIL sq_pre: got %0d want 9", infl_cnt); end
    squash      = 1'b1;
    squash_cnt  = 5'd5;
    squash_type = RAS_PUSH;
    lookup_req  = 1'b1;
    lookup_type = RAS_PUSH;
    #1;
    nVec++; if (ras_update !== 1'b0) begin nErr++; $display("[TB] FAIL sq_block: got %b want 0", ras_update); end
    nVec++; if (ras_upd_info.fsqIdx !== 6'd12) begin nErr++; $display("[TB] FAIL sq_head: got %0d want 12", ras_upd_info.fsqIdx); end
    tick();
    idle();
    #1;
    nVec++; if (infl_cnt !== 5'd6) begin nErr++; $display("[TB] FAIL sq_cnt: got %0d want 6", infl_cnt); end
    nVec++; if (ras_update !== 1'b1 || ras_upd_info.fsqIdx !== 6'd12) begin nErr++; $display("[TB] FAIL sq_next: got upd=%b idx=%0d want 1/12", ras_update, ras_upd_info.fsqIdx); end
    tick();
    nVec++; if (infl_cnt !== 5'd5 || ras_update !== 1'b0) begin nErr++; $display("[TB] FAIL sq_post: got cnt=%0d upd=%b want 5/0", infl_cnt, ras_update); end
  endtask

  task automatic test_error();
    idle();
    squash = 1'b1;
    squash_cnt = 5'd0;
    upd_valid = 1'b1;
    upd_info  = mkReq(BR_CALL, 1'b1, 6'd30);
    tick();
    idle();
    #1;
    nVec++; if (err !== 1'b0 || ras_update !== 1'b1) begin nErr++; $display("[TB] FAIL err_pre: got err=%b upd=%b want 0/1", err, ras_update); end
    tick();
    nVec++; if (err !== 1'b1) begin nErr++; $display("[TB] FAIL err_underflow: got %b want 1", err); end
    nVec++; if (infl_cnt !== 5'd0) begin nErr++; $display("[TB] FAIL err_sat0: got %0d want 0", infl_cnt); end
    squash      = 1'b1;
    squash_cnt  = 5'd3;
    squash_type = RAS_POP_PUSH;
    upd_valid   = 1'b1;
    upd_info    = mkReq(BR_CALL, 1'b1, 6'd31);
    tick();
    idle();
    lookup_req  = 1'b1;
    lookup_type = RAS_PUSH;
    #1;
    nVec++; if (infl_cnt !== 5'd3 || ras_update !== 1'b1) begin nErr++; $display("[TB] FAIL both_pre: got cnt=%0d upd=%b want 3/1", infl_cnt, ras_update); end
    tick();
    idle();
    #1;
    nVec++; if (infl_cnt !== 5'd3) begin nErr++; $display("[TB] FAIL both_net0: got %0d want 3", infl_cnt); end
    squash     = 1'b1;
    squash_cnt = 5'd16;
    tick();
    idle();
    lookup_req  = 1'b1;
    lookup_type = RAS_PUSH;
    tick();
    idle();
    #1;
    nVec++; if (infl_cnt !== 5'd16 || err !== 1'b1) begin nErr++; $display("[TB] FAIL err_overflow: got cnt=%0d err=%b want 16/1", infl_cnt, err); end
    rst = 1'b1;
    #1;
    nVec++; if (err !== 1'b0 || infl_cnt !== 5'd0) begin nErr++; $display("[TB] FAIL err_clear: got err=%b cnt=%0d want 0/0", err, infl_cnt); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    test_reset();
    test_filter();
    test_full();
    test_stall();
    test_squash();
    test_error();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish, limit 100000 time units");
    $fatal(1);
  end

endmodule
